// File: rtl/resp_bist_pkg.sv
// Shared types and helpers for the response-compaction BIST blocks.
// fold_resp XORs SIG_WIDTH-bit slices of a zero-padded response vector.
package resp_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

  // Upper bounds for the folding helper; callers zero-extend into these.
  localparam int MAX_RESP_W = 512;
  localparam int MAX_SIG_W  = 64;

  // Bit i of the response lands in signature bit (i mod sig_w).
  // This is the XOR of all sig_w-bit slices after MSB zero-padding.
  function automatic logic [MAX_SIG_W-1:0] fold_resp(
    input logic [MAX_RESP_W-1:0] resp,
    input int                    resp_w,
    input int                    sig_w
  );
    logic [MAX_SIG_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_RESP_W; i++) begin
      if (i < resp_w) begin
        acc[i % sig_w] = acc[i % sig_w] ^ resp[i];
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: shift left, fold in POLY on MSB
// carry-out, XOR in the parallel data word.
module misr_core #(
  parameter int                   SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY      = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [SIG_WIDTH-1:0] seed,
  input  logic                 en,
  input  logic [SIG_WIDTH-1:0] data_in,
  output logic [SIG_WIDTH-1:0] sig,
  output logic [SIG_WIDTH-1:0] sig_step
);

  always_comb begin
    sig_step = {sig[SIG_WIDTH-2:0], 1'b0}
             ^ (sig[SIG_WIDTH-1] ? POLY : '0)
             ^ data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= RESET_VAL;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= sig_step;
    end
  end

endmodule

// File: rtl/resp_misr_capture.sv
// Compacts NUM_VEC CUT response vectors into a MISR signature and shifts it
// out MSB first over a valid/ready link, pulsing done after the last bit.
module resp_misr_capture
  import resp_bist_pkg::*;
#(
  parameter int                   RESP_WIDTH = 123,
  parameter int                   NUM_VEC    = 7,
  parameter int                   SIG_WIDTH  = 32,
  parameter logic [SIG_WIDTH-1:0] POLY       = DEFAULT_POLY,
  parameter logic [SIG_WIDTH-1:0] SEED       = '0,
  localparam int                  CW         = $clog2(NUM_VEC + 1),
  localparam int                  BW         = $clog2(SIG_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  resp_valid,
  input  logic [RESP_WIDTH-1:0] resp,
  output logic                  busy,
  output logic [CW-1:0]         vec_count,
  output logic                  sig_valid,
  input  logic                  sig_ready,
  output logic                  sig_bit,
  output logic                  done,
  output state_t                state
);

  // Serial link: a bit transfers on every cycle where sig_valid && sig_ready;
  // sig_bit and sig_valid are held unchanged until that happens.

  state_t                 state_q, state_d;
  logic [BW-1:0]          bit_cnt;
  logic [SIG_WIDTH-1:0]   shreg;
  logic [SIG_WIDTH-1:0]   misr_sig, misr_step;
  logic [MAX_RESP_W-1:0]  resp_ext;
  logic [MAX_SIG_W-1:0]   fold_w;
  logic [SIG_WIDTH-1:0]   fold_data;
  logic                   unused_fold_hi;
  logic                   go, absorb, last_vec, xfer, last_bit;

  always_comb begin
    resp_ext                 = '0;
    resp_ext[RESP_WIDTH-1:0] = resp;
    fold_w                   = fold_resp(resp_ext, RESP_WIDTH, SIG_WIDTH);
    fold_data                = fold_w[SIG_WIDTH-1:0];
  end

  assign unused_fold_hi = ^fold_w[MAX_SIG_W-1:SIG_WIDTH] ^ ^misr_sig;

  misr_core #(
    .SIG_WIDTH (SIG_WIDTH),
    .POLY      (POLY),
    .RESET_VAL (SEED)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (go),
    .seed     (SEED),
    .en       (absorb),
    .data_in  (fold_data),
    .sig      (misr_sig),
    .sig_step (misr_step)
  );

  always_comb begin
    state_d  = state_q;
    go       = 1'b0;
    absorb   = 1'b0;
    last_vec = 1'b0;
    xfer     = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          go      = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (resp_valid) begin
          absorb = 1'b1;
          if (vec_count == CW'(NUM_VEC - 1)) begin
            last_vec = 1'b1;
            state_d  = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (sig_valid && sig_ready) begin
          xfer = 1'b1;
          if (bit_cnt == BW'(SIG_WIDTH - 1)) begin
            last_bit = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      sig_valid <= 1'b0;
      done      <= 1'b0;
      vec_count <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != IDLE);
      sig_valid <= (state_d == SHIFT);
      done      <= last_bit;
      if (go) begin
        vec_count <= '0;
      end else if (absorb) begin
        vec_count <= vec_count + 1'b1;
      end
      // The shift copy is taken from the step value so the first bit is
      // presented the cycle right after the final vector is absorbed.
      if (last_vec) begin
        bit_cnt <= '0;
        shreg   <= misr_step;
      end else if (xfer) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {shreg[SIG_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign sig_bit = shreg[SIG_WIDTH-1];
  assign state   = state_q;

endmodule
